// File: rtl/rvh_l1d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvh_l1d_pkg
// Brief    : Shared types for the L1D-to-L2 AXI path (channel structs, resp
//            codes, memory-slave FSM encoding).
// Revision : 1.0
// ============================================================================
package rvh_l1d_pkg;

    localparam int PADDR_W       = 32;
    localparam int MEM_DATA_W    = 64;
    localparam int MEM_STRB_W    = MEM_DATA_W / 8;
    localparam int L1D_BANK_ID_W = 2;
    localparam int MEM_TID_W     = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [L1D_BANK_ID_W-1:0] bid;
        logic [MEM_TID_W-1:0]     tid;
    } mem_tid_t;

    typedef struct packed {
        mem_tid_t           arid;
        logic [PADDR_W-1:0] araddr;
        logic [7:0]         arlen;
    } cache_mem_if_ar_t;

    typedef struct packed {
        mem_tid_t           awid;
        logic [PADDR_W-1:0] awaddr;
        logic [7:0]         awlen;
    } cache_mem_if_aw_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_STRB_W-1:0] wstrb;
        logic                  wlast;
    } cache_mem_if_w_t;

    typedef struct packed {
        mem_tid_t   bid;
        logic [1:0] bresp;
    } cache_mem_if_b_t;

    typedef struct packed {
        mem_tid_t              rid;
        logic [MEM_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
    } cache_mem_if_r_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR_DATA  = 3'd3,
        WR_RESP  = 3'd4
    } axi_mem_slv_fsm_e;

endpackage
`default_nettype wire

// File: rtl/rvh_axi_mem_slv_ram.sv
`default_nettype none
// ============================================================================
// Module   : rvh_axi_mem_slv_ram
// Brief    : Word array with byte-strobed write port and registered read port.
// Revision : 1.0
// ============================================================================
module rvh_axi_mem_slv_ram #(
    parameter int MEM_DEPTH = 1024,
    parameter int MEM_IDX_W = $clog2(MEM_DEPTH),
    parameter int DATA_W    = 64,
    parameter int STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [MEM_IDX_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [MEM_IDX_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // The array itself is never reset so its contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    r_mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_idx];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/rvh_l1d_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : rvh_l1d_axi_mem_slave
// Brief    : AXI responder backing the L1D-to-L2 request path with a word array.
// Revision : 1.0
// ============================================================================
module rvh_l1d_axi_mem_slave
    import rvh_l1d_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int MEM_IDX_W = $clog2(MEM_DEPTH),
    parameter int ADDR_LSB  = $clog2(MEM_DATA_W / 8),
    parameter int RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arvalid,
    output logic             arready,
    input  cache_mem_if_ar_t ar,
    input  logic             awvalid,
    output logic             awready,
    input  cache_mem_if_aw_t aw,
    input  logic             wvalid,
    output logic             wready,
    input  cache_mem_if_w_t  w,
    output logic             bvalid,
    input  logic             bready,
    output cache_mem_if_b_t  b,
    output logic             rvalid,
    input  logic             rready,
    output cache_mem_if_r_t  r
);

    localparam logic [1:0] c_WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    axi_mem_slv_fsm_e     r_state;
    logic                 r_rr_last_rd;
    logic [MEM_IDX_W-1:0] r_idx;
    logic [7:0]           r_len;
    logic [7:0]           r_beat;
    mem_tid_t             r_id;
    logic                 r_err;
    logic                 r_past_len;
    logic [1:0]           r_wait_cnt;
    logic                 r_rvalid;
    logic                 r_rlast;
    mem_tid_t             r_rid;
    logic [1:0]           r_rresp;
    logic                 r_wready;
    logic                 r_bvalid;
    cache_mem_if_b_t      r_b;

    logic                  w_idle;
    logic                  w_grant_rd;
    logic                  w_ar_hs;
    logic                  w_aw_hs;
    logic                  w_r_hs;
    logic                  w_w_hs;
    logic                  w_len_hit;
    logic                  w_err_nxt;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic [MEM_IDX_W-1:0]  w_ar_idx;
    logic [MEM_IDX_W-1:0]  w_aw_idx;
    logic [MEM_IDX_W-1:0]  w_rd_idx;
    logic [MEM_DATA_W-1:0] w_rdata;
    logic                  w_unused_addr;

    assign w_idle     = (r_state == IDLE);
    // On contention the type not served last wins; otherwise the lone requester wins.
    assign w_grant_rd = arvalid & (~awvalid | ~r_rr_last_rd);
    assign arready    = rst & w_idle & w_grant_rd;
    assign awready    = rst & w_idle & awvalid & ~w_grant_rd;
    assign w_ar_hs    = arvalid & arready;
    assign w_aw_hs    = awvalid & awready;
    assign w_r_hs     = r_rvalid & rready;
    assign w_w_hs     = wvalid & r_wready;
    assign w_len_hit  = (r_beat == r_len);
    assign w_err_nxt  = r_err | (w.wlast ^ w_len_hit);
    assign w_ar_idx   = ar.araddr[ADDR_LSB +: MEM_IDX_W];
    assign w_aw_idx   = aw.awaddr[ADDR_LSB +: MEM_IDX_W];

    // Reads are issued one cycle ahead so the registered RAM output lines up with rvalid.
    assign w_rd_en  = w_ar_hs | ((r_state == RD_BURST) & w_r_hs & ~r_rlast);
    assign w_rd_idx = w_idle ? w_ar_idx : r_idx + 1'b1;
    assign w_wr_en  = (r_state == WR_DATA) & w_w_hs & ~r_past_len;

    assign w_unused_addr = ^{ar.araddr, aw.awaddr};

    rvh_axi_mem_slv_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_IDX_W (MEM_IDX_W),
        .DATA_W    (MEM_DATA_W),
        .STRB_W    (MEM_STRB_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (w_rd_en),
        .rd_idx  (w_rd_idx),
        .rd_data (w_rdata),
        .wr_en   (w_wr_en),
        .wr_idx  (r_idx),
        .wr_data (w.wdata),
        .wr_strb (w.wstrb)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_rr_last_rd <= 1'b0;
            r_idx        <= '0;
            r_len        <= '0;
            r_beat       <= '0;
            r_id         <= '0;
            r_err        <= 1'b0;
            r_past_len   <= 1'b0;
            r_wait_cnt   <= '0;
            r_rvalid     <= 1'b0;
            r_rlast      <= 1'b0;
            r_rid        <= '0;
            r_rresp      <= AXI_RESP_OKAY;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_b          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        if (awvalid) r_rr_last_rd <= ~r_rr_last_rd;
                        r_id       <= ar.arid;
                        r_idx      <= w_ar_idx;
                        r_len      <= ar.arlen;
                        r_beat     <= '0;
                        r_wait_cnt <= c_WAIT_INIT;
                        r_rid      <= ar.arid;
                        r_rresp    <= AXI_RESP_OKAY;
                        r_rlast    <= (ar.arlen == 8'd0);
                        if (RD_LAT > 1) begin
                            r_state <= RD_WAIT;
                        end else begin
                            r_state  <= RD_BURST;
                            r_rvalid <= 1'b1;
                        end
                    end else if (w_aw_hs) begin
                        if (arvalid) r_rr_last_rd <= ~r_rr_last_rd;
                        r_id       <= aw.awid;
                        r_idx      <= w_aw_idx;
                        r_len      <= aw.awlen;
                        r_beat     <= '0;
                        r_err      <= 1'b0;
                        r_past_len <= 1'b0;
                        r_wready   <= 1'b1;
                        r_state    <= WR_DATA;
                    end
                end
                RD_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_state  <= RD_BURST;
                        r_rvalid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                RD_BURST: begin
                    if (w_r_hs) begin
                        r_idx  <= r_idx + 1'b1;
                        r_beat <= r_beat + 8'd1;
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_rlast <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                WR_DATA: begin
                    if (w_w_hs) begin
                        r_idx  <= r_idx + 1'b1;
                        r_beat <= r_beat + 8'd1;
                        r_err  <= w_err_nxt;
                        // Beats beyond the announced length are absorbed but not written.
                        if (w_len_hit && !w.wlast) r_past_len <= 1'b1;
                        if (w.wlast) begin
                            r_wready  <= 1'b0;
                            r_bvalid  <= 1'b1;
                            r_b.bid   <= r_id;
                            r_b.bresp <= w_err_nxt ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                            r_state   <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rvalid = r_rvalid;
    assign wready = r_wready;
    assign bvalid = r_bvalid;
    assign b      = r_b;
    assign r      = '{rid: r_rid, rdata: w_rdata, rresp: r_rresp, rlast: r_rlast};

endmodule
`default_nettype wire

// File: tb/tb_rvh_l1d_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvh_l1d_axi_mem_slave
// Brief    : Directed self-checking bench for the L1D AXI memory slave.
// Revision : 1.0
// ============================================================================
module tb_rvh_l1d_axi_mem_slave;
    import rvh_l1d_pkg::*;

    localparam int c_ADDR_LSB = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             arvalid, arready, awvalid, awready;
    logic             wvalid, wready, bvalid, bready, rvalid, rready;
    cache_mem_if_ar_t ar;
    cache_mem_if_aw_t aw;
    cache_mem_if_w_t  w;
    cache_mem_if_b_t  b;
    cache_mem_if_r_t  r;

    int               n_checks = 0;
    int               n_errors = 0;
    int               first_lat;
    cache_mem_if_r_t  rq[$];
    cache_mem_if_b_t  bres;

    rvh_l1d_axi_mem_slave dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .ar(ar),
        .awvalid(awvalid), .awready(awready), .aw(aw),
        .wvalid(wvalid), .wready(wready), .w(w),
        .bvalid(bvalid), .bready(bready), .b(b),
        .rvalid(rvalid), .rready(rready), .r(r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic mem_tid_t mk_id(input int bank, input int tid);
        mem_tid_t id;
        id.bid = 2'(bank);
        id.tid = 4'(tid);
        return id;
    endfunction

    task automatic ar_issue(input int idx, input int len, input mem_tid_t id);
        int n = 0;
        logic ok = 1'b0;
        arvalid = 1'b1;
        ar.arid = id; ar.araddr = 32'(idx << c_ADDR_LSB); ar.arlen = 8'(len);
        while (n < 50) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
            n++;
        end
        chk("ar_handshake", ok, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic aw_issue(input int idx, input int len, input mem_tid_t id);
        int n = 0;
        logic ok = 1'b0;
        awvalid = 1'b1;
        aw.awid = id; aw.awaddr = 32'(idx << c_ADDR_LSB); aw.awlen = 8'(len);
        while (n < 50) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
            n++;
        end
        chk("aw_handshake", ok, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_send(input int nbeats, input logic [63:0] d0, input logic [63:0] step);
        for (int k = 0; k < nbeats; k++) begin
            int n = 0;
            logic ok = 1'b0;
            wvalid = 1'b1;
            w.wdata = d0 + step * 64'(k); w.wstrb = '1; w.wlast = (k == nbeats - 1);
            while (n < 50) begin
                @(negedge clk);
                if (wready) begin ok = 1'b1; break; end
                n++;
            end
            chk("w_handshake", ok, 1'b1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; w.wlast = 1'b0;
    endtask

    task automatic b_collect();
        int n = 0;
        logic ok = 1'b0;
        bready = 1'b1;
        while (n < 50) begin
            @(negedge clk);
            if (bvalid) begin ok = 1'b1; bres = b; break; end
            n++;
        end
        chk("b_handshake", ok, 1'b1);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    // rready follows pat[cycle % 16]; any beat held under stall must not change.
    task automatic r_collect(input int len, input logic [15:0] pat);
        int cyc = 0;
        int beats = 0;
        logic stall = 1'b0;
        cache_mem_if_r_t prev = '0;
        rq.delete();
        first_lat = -1;
        while (beats < len + 1 && cyc < 64) begin
            rready = pat[cyc % 16];
            @(negedge clk);
            if (stall) chk("r_stable", r, prev);
            if (rvalid && first_lat < 0) first_lat = cyc;
            stall = rvalid && !rready;
            prev  = r;
            if (rvalid && rready) begin rq.push_back(r); beats++; end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        chk("r_beat_count", beats, len + 1);
        @(negedge clk);
        chk("r_idle_after", rvalid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mem_tid_t id;
        int rd_left, wr_left, n;
        logic ok, got_rd;

        rst = 1'b0; arvalid = 1'b1; awvalid = 1'b0; wvalid = 1'b1;
        bready = 1'b0; rready = 1'b0; ar = '0; aw = '0; w = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_r", r, '0);
        chk("rst_b", b, '0);
        @(posedge clk); #1;
        rst = 1'b1; arvalid = 1'b0;
        @(negedge clk);
        chk("early_w_wready", wready, 1'b0);
        chk("idle_awready", awready, 1'b0);
        @(posedge clk); #1;
        wvalid = 1'b0;

        // Single-beat read of a preloaded word.
        aw_issue(5, 0, mk_id(0, 0));
        w_send(1, 64'hA5A5, 64'h0);
        b_collect();
        chk("pre5_bresp", bres.bresp, 2'b00);
        id = mk_id(3, 1);
        ar_issue(5, 0, id);
        r_collect(0, 16'hFFFF);
        chk("rd1_latency", first_lat, 0);
        chk("rd1_rdata", rq[0].rdata, 64'hA5A5);
        chk("rd1_bankid", rq[0].rid.bid, 2'd3);
        chk("rd1_rid", rq[0].rid, id);
        chk("rd1_rlast", rq[0].rlast, 1'b1);
        chk("rd1_rresp", rq[0].rresp, 2'b00);

        // Four-beat write followed by read-back.
        id = mk_id(1, 2);
        aw_issue(8, 3, id);
        w_send(4, 64'h11, 64'h11);
        b_collect();
        chk("wr4_bresp", bres.bresp, 2'b00);
        chk("wr4_bid", bres.bid, id);
        id = mk_id(2, 5);
        ar_issue(8, 3, id);
        r_collect(3, 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            chk("rd4_rdata", rq[k].rdata, 64'h11 * 64'(k + 1));
            chk("rd4_rlast", rq[k].rlast, (k == 3));
            chk("rd4_rid", rq[k].rid, id);
        end

        // Backpressure on a two-beat read.
        ar_issue(8, 1, mk_id(0, 7));
        r_collect(1, 16'hFFF9);
        chk("bp_count", rq.size(), 2);
        chk("bp_beat0", rq[0].rdata, 64'h11);
        chk("bp_beat1", rq[1].rdata, 64'h22);
        chk("bp_rlast", rq[1].rlast, 1'b1);

        // Reset keeps array contents; arbitration restarts favouring reads.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ar.arid = mk_id(1, 3); ar.araddr = 32'(8 << c_ADDR_LSB); ar.arlen = 8'd0;
        aw.awid = mk_id(2, 4); aw.awaddr = 32'(40 << c_ADDR_LSB); aw.awlen = 8'd0;
        rd_left = 3; wr_left = 3;
        for (int i = 0; i < 6; i++) begin
            arvalid = (rd_left > 0); awvalid = (wr_left > 0);
            n = 0; ok = 1'b0;
            while (n < 50) begin
                @(negedge clk);
                if (arready || awready) begin ok = 1'b1; break; end
                n++;
            end
            got_rd = arready;
            chk("arb_grant", ok, 1'b1);
            chk("arb_order", got_rd, (i % 2 == 0));
            @(posedge clk); #1;
            arvalid = 1'b0; awvalid = 1'b0;
            if (got_rd) begin
                rd_left--;
                r_collect(0, 16'hFFFF);
                chk("arb_rdata", rq[0].rdata, 64'h11);
            end else begin
                wr_left--;
                w_send(1, 64'hC0 + 64'(i), 64'h0);
                b_collect();
                chk("arb_bid", bres.bid, mk_id(2, 4));
            end
        end
        ar_issue(5, 0, mk_id(0, 1));
        r_collect(0, 16'hFFFF);
        chk("preserved_mem5", rq[0].rdata, 64'hA5A5);

        // Burst wraps from the top index to index 0.
        aw_issue(1023, 1, mk_id(1, 1));
        w_send(2, 64'hDEAD0001, 64'h1);
        b_collect();
        chk("wrap_bresp", bres.bresp, 2'b00);
        ar_issue(0, 0, mk_id(1, 1));
        r_collect(0, 16'hFFFF);
        chk("wrap_mem0", rq[0].rdata, 64'hDEAD0002);
        ar_issue(1023, 1, mk_id(1, 1));
        r_collect(1, 16'hFFFF);
        chk("wrap_rd_top", rq[0].rdata, 64'hDEAD0001);
        chk("wrap_rd_zero", rq[1].rdata, 64'hDEAD0002);

        // Short burst: wlast arrives on beat 2 of 4.
        id = mk_id(3, 9);
        aw_issue(12, 3, id);
        w_send(2, 64'h77, 64'h1);
        b_collect();
        chk("short_bresp", bres.bresp, 2'b10);
        chk("short_bid", bres.bid, id);

        // Long burst: the beat past awlen is flagged and dropped.
        aw_issue(17, 0, mk_id(0, 2));
        w_send(1, 64'h55, 64'h0);
        b_collect();
        aw_issue(16, 0, mk_id(0, 3));
        w_send(2, 64'hAB, 64'h22);
        b_collect();
        chk("long_bresp", bres.bresp, 2'b10);
        ar_issue(16, 1, mk_id(0, 3));
        r_collect(1, 16'hFFFF);
        chk("long_mem16", rq[0].rdata, 64'hAB);
        chk("long_mem17", rq[1].rdata, 64'h55);

        // Reset during beat 2 of a 4-beat read abandons the burst.
        ar_issue(8, 3, mk_id(2, 2));
        rready = 1'b1;
        @(negedge clk);
        chk("mid_beat1", r.rdata, 64'h11);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_beat2", r.rdata, 64'h22);
        @(posedge clk); #1;
        rst = 1'b1; rready = 1'b0;
        @(negedge clk);
        chk("mid_rvalid", rvalid, 1'b0);
        chk("mid_r_clear", r, '0);
        @(posedge clk); #1;
        id = mk_id(1, 6);
        ar_issue(5, 0, id);
        r_collect(0, 16'hFFFF);
        chk("post_rst_rdata", rq[0].rdata, 64'hA5A5);
        chk("post_rst_rid", rq[0].rid, id);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
